seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2 to 2^20.
REQ-002 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: en  input  1  scan enable; 0 freezes the scan and blanks every digit.
REQ-005 Port: load  input  1  single-cycle strobe that captures value_in.
REQ-006 Port: value_in  input  16  four BCD/hex nibbles; [3:0] is the rightmost digit.
REQ-007 Port: blank_lz  input  1  1 enables leading-zero blanking.
REQ-008 Port: value_out  output  16  displayed value; feeds the downstream nibble mux data input.
REQ-009 Port: select  output  4  one-hot digit select; feeds the downstream nibble mux select.
REQ-010 Port: an  output  4  active-low anode drive, one bit per digit.
REQ-011 Port: pending  output  1  1 while a loaded value waits for the frame boundary.
REQ-012 Port: digit_tick  output  1  one-cycle pulse on each select advance.

Function
REQ-013 Prescaler counts 0..REFRESH_DIV-1 while en=1, wraps to 0 and holds its value while en=0.
REQ-014 On the cycle the prescaler is at REFRESH_DIV-1 with en=1, digit_tick shall be 1 and select shall advance on that edge: 0001->0010->0100->1000->0001.
REQ-015 select shall be exactly one-hot at all times; no other encoding shall ever appear.
REQ-016 A frame boundary is the advance from 1000 to 0001.
REQ-017 load=1 writes value_in into a shadow register and sets pending; a later load before the boundary overwrites it (last wins).
REQ-018 At a frame boundary with pending=1, value_out takes the shadow value and pending clears on the same edge.
REQ-019 With load=1 on a frame-boundary cycle, value_out takes value_in directly and pending stays 0.
REQ-020 value_out shall never change except at a frame boundary or reset (no tearing mid-frame).
REQ-021 With en=1: an = ~select, except that digit k (k=3..1) is forced high when blank_lz=1 and value_out nibbles k..3 are all zero; digit 0 is never blanked.
REQ-022 With en=0: an = 1111; select, value_out, shadow and pending hold; load is still accepted into the shadow.
REQ-023 an shall be decoded from registered state only (no path from value_in or load).

Reset
REQ-024 With rst=1 at a clk edge: prescaler=0, select=0001, value_out=0000, shadow=0000, pending=0, digit_tick=0.
REQ-025 rst shall take priority over load and en; a load in the reset cycle is discarded.
REQ-026 After reset with en=1, an=1110 until the first digit_tick.

Structure
REQ-027 Package seg_pkg holds NUM_DIGITS=4, NIBBLE_W=4, the one-hot constants DIG0..DIG3, and the anode-off constant 4'b1111.
REQ-028 The prescaler shall be sub-module tick_gen (params DIV; ports clk, rst, en, tick).
REQ-029 Select rotation, shadow/pending logic and anode decode shall stay in seg_scan_ctrl.

Verification (bench uses REFRESH_DIV=4)
REQ-030 Reset then en=1 for 20 cycles -> digit_tick every 4th cycle; select 0001,0010,0100,1000,0001; an tracks ~select.
REQ-031 load value_in=16'h1234 while select=0010 -> pending=1 and value_out=0000 until the 1000->0001 edge, then value_out=1234 and pending=0.
REQ-032 load 16'hAAAA then 16'h5555 within one frame -> value_out=5555 at the boundary; AAAA is never displayed.
REQ-033 blank_lz=1 with value_out=16'h0007 -> an=1110 in slot 0 and 1111 in slots 1-3; with value_out=16'h0000, digit 0 is still lit.
REQ-034 en dropped mid-frame for 10 cycles -> an=1111 and select/prescaler frozen; on resume the scan continues from the held state.
REQ-035 rst asserted with pending=1 while select=0100 -> next cycle select=0001, value_out=0000, pending=0.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared widths and one-hot/anode constants for the seven-segment scanner
package seg_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W = 4;
    localparam logic [NUM_DIGITS-1:0] DIG0 = 4'b0001;
    localparam logic [NUM_DIGITS-1:0] DIG1 = 4'b0010;
    localparam logic [NUM_DIGITS-1:0] DIG2 = 4'b0100;
    localparam logic [NUM_DIGITS-1:0] DIG3 = 4'b1000;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler that pulses tick once every DIV enabled cycles
module tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt;
    assign tick = en && (cnt == W'(DIV - 1));
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed display scanner with frame-synchronous value update
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic        blank_lz,
    output logic [15:0] value_out,
    output logic [3:0]  select,
    output logic [3:0]  an,
    output logic        pending,
    output logic        digit_tick
);
    logic [15:0] shadow;
    logic boundary;
    logic [NUM_DIGITS-1:1] lz;
    tick_gen #(.DIV(REFRESH_DIV)) u_tick (
        .clk(clk),
        .rst(rst),
        .en(en),
        .tick(digit_tick)
    );
    assign boundary = digit_tick && (select == DIG3);
    always_ff @(posedge clk) begin
        if (rst) begin
            select <= DIG0;
            value_out <= '0;
            shadow <= '0;
            pending <= 1'b0;
        end else begin
            if (digit_tick)
                select <= {select[NUM_DIGITS-2:0], select[NUM_DIGITS-1]};
            if (boundary && load) begin
                value_out <= value_in;
                pending <= 1'b0;
            end else if (boundary && pending) begin
                value_out <= shadow;
                pending <= 1'b0;
            end else if (load) begin
                shadow <= value_in;
                pending <= 1'b1;
            end
        end
    end
    // lz[k] is set when nibbles k..3 of the displayed value are all zero
    always_comb begin
        lz[3] = value_out[15:12] == '0;
        for (int k = 2; k >= 1; k--)
            lz[k] = lz[k+1] && (value_out[k*NIBBLE_W +: NIBBLE_W] == '0);
        an = !en ? AN_OFF : (~select | ({lz, 1'b0} & {NUM_DIGITS{blank_lz}}));
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed table and corner-case sequences for seg_scan_ctrl
module tb_seg_scan_ctrl;
    logic clk = 0, rst = 0, en = 0, load = 0, blank_lz = 0;
    logic [15:0] value_in = '0, value_out;
    logic [3:0] select, an;
    logic pending, digit_tick;
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic en, ld;
        logic [15:0] val;
        logic blz;
        logic [3:0] sel, an;
        logic [15:0] vo;
        logic pend, tick;
    } vec_t;

    seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .value_in(value_in),
        .blank_lz(blank_lz), .value_out(value_out), .select(select), .an(an),
        .pending(pending), .digit_tick(digit_tick)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic e, logic l, logic [15:0] v, logic b, logic [3:0] s,
                                logic [3:0] a, logic [15:0] o, logic p, logic t);
        vec_t r;
        r.en = e; r.ld = l; r.val = v; r.blz = b; r.sel = s; r.an = a; r.vo = o; r.pend = p; r.tick = t;
        return r;
    endfunction

    task automatic cmp(string tag, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic apply(vec_t v, string tag);
        en = v.en; load = v.ld; value_in = v.val; blank_lz = v.blz;
        #1;
        cmp({tag, " select"}, 16'(select), 16'(v.sel));
        cmp({tag, " an"}, 16'(an), 16'(v.an));
        cmp({tag, " value_out"}, value_out, v.vo);
        cmp({tag, " pending"}, 16'(pending), 16'(v.pend));
        cmp({tag, " digit_tick"}, 16'(digit_tick), 16'(v.tick));
        cmp({tag, " onehot"}, 16'($countones(select)), 16'd1);
        @(negedge clk);
        load = 0;
    endtask

    task automatic run(int n, logic e, logic b);
        en = e; blank_lz = b; load = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; en = 0; load = 0; blank_lz = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    vec_t tbl[34];

    initial begin
        tbl[0]  = mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h0000, 0, 0);
        tbl[1]  = mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h0000, 0, 0);
        tbl[2]  = mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h0000, 0, 0);
        tbl[3]  = mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h0000, 0, 1);
        tbl[4]  = mk(1, 0, 16'h0000, 0, 4'h2, 4'hD, 16'h0000, 0, 0);
        tbl[5]  = mk(1, 1, 16'h1234, 0, 4'h2, 4'hD, 16'h0000, 0, 0);
        tbl[6]  = mk(1, 0, 16'h0000, 0, 4'h2, 4'hD, 16'h0000, 1, 0);
        tbl[7]  = mk(1, 0, 16'h0000, 0, 4'h2, 4'hD, 16'h0000, 1, 1);
        tbl[8]  = mk(1, 0, 16'h0000, 0, 4'h4, 4'hB, 16'h0000, 1, 0);
        tbl[9]  = mk(1, 0, 16'h0000, 0, 4'h4, 4'hB, 16'h0000, 1, 0);
        tbl[10] = mk(1, 0, 16'h0000, 0, 4'h4, 4'hB, 16'h0000, 1, 0);
        tbl[11] = mk(1, 0, 16'h0000, 0, 4'h4, 4'hB, 16'h0000, 1, 1);
        tbl[12] = mk(1, 0, 16'h0000, 0, 4'h8, 4'h7, 16'h0000, 1, 0);
        tbl[13] = mk(1, 0, 16'h0000, 0, 4'h8, 4'h7, 16'h0000, 1, 0);
        tbl[14] = mk(1, 0, 16'h0000, 0, 4'h8, 4'h7, 16'h0000, 1, 0);
        tbl[15] = mk(1, 0, 16'h0000, 0, 4'h8, 4'h7, 16'h0000, 1, 1);
        tbl[16] = mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h1234, 0, 0);
        tbl[17] = mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h1234, 0, 0);
        tbl[18] = mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h1234, 0, 0);
        tbl[19] = mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h1234, 0, 1);
        tbl[20] = mk(1, 1, 16'hAAAA, 0, 4'h2, 4'hD, 16'h1234, 0, 0);
        tbl[21] = mk(1, 0, 16'h0000, 0, 4'h2, 4'hD, 16'h1234, 1, 0);
        tbl[22] = mk(1, 1, 16'h5555, 0, 4'h2, 4'hD, 16'h1234, 1, 0);
        tbl[23] = mk(1, 0, 16'h0000, 0, 4'h2, 4'hD, 16'h1234, 1, 1);
        tbl[24] = mk(1, 0, 16'h0000, 0, 4'h4, 4'hB, 16'h1234, 1, 0);
        tbl[25] = mk(1, 0, 16'h0000, 0, 4'h4, 4'hB, 16'h1234, 1, 0);
        tbl[26] = mk(1, 0, 16'h0000, 0, 4'h4, 4'hB, 16'h1234, 1, 0);
        tbl[27] = mk(1, 0, 16'h0000, 0, 4'h4, 4'hB, 16'h1234, 1, 1);
        tbl[28] = mk(1, 0, 16'h0000, 0, 4'h8, 4'h7, 16'h1234, 1, 0);
        tbl[29] = mk(1, 0, 16'h0000, 0, 4'h8, 4'h7, 16'h1234, 1, 0);
        tbl[30] = mk(1, 0, 16'h0000, 0, 4'h8, 4'h7, 16'h1234, 1, 0);
        tbl[31] = mk(1, 0, 16'h0000, 0, 4'h8, 4'h7, 16'h1234, 1, 1);
        tbl[32] = mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h5555, 0, 0);
        tbl[33] = mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h5555, 0, 0);

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 34; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // load landing exactly on the boundary cycle bypasses the shadow
        do_reset();
        run(15, 1, 0);
        apply(mk(1, 1, 16'hBEEF, 0, 4'h8, 4'h7, 16'h0000, 0, 1), "bnd_load");
        apply(mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'hBEEF, 0, 0), "bnd_after");

        // leading-zero blanking
        do_reset();
        apply(mk(1, 1, 16'h0007, 0, 4'h1, 4'hE, 16'h0000, 0, 0), "lz_load");
        run(15, 1, 1);
        apply(mk(1, 0, 16'h0000, 1, 4'h1, 4'hE, 16'h0007, 0, 0), "lz7_s0");
        run(3, 1, 1);
        apply(mk(1, 0, 16'h0000, 1, 4'h2, 4'hF, 16'h0007, 0, 0), "lz7_s1");
        run(3, 1, 1);
        apply(mk(1, 0, 16'h0000, 1, 4'h4, 4'hF, 16'h0007, 0, 0), "lz7_s2");
        run(3, 1, 1);
        apply(mk(1, 1, 16'h0000, 1, 4'h8, 4'hF, 16'h0007, 0, 0), "lz7_s3");
        run(3, 1, 1);
        apply(mk(1, 0, 16'h0000, 1, 4'h1, 4'hE, 16'h0000, 0, 0), "lz0_s0");
        run(3, 1, 1);
        apply(mk(1, 0, 16'h0000, 1, 4'h2, 4'hF, 16'h0000, 0, 0), "lz0_s1");

        // enable dropped mid-slot: everything freezes, load still captured
        apply(mk(1, 0, 16'h0000, 0, 4'h2, 4'hD, 16'h0000, 0, 0), "pre_freeze");
        for (int i = 0; i < 10; i++)
            apply(mk(0, i == 3, 16'h1111, 0, 4'h2, 4'hF, 16'h0000, i > 3, 0), $sformatf("freeze[%0d]", i));
        apply(mk(1, 0, 16'h0000, 0, 4'h2, 4'hD, 16'h0000, 1, 0), "resume0");
        apply(mk(1, 0, 16'h0000, 0, 4'h2, 4'hD, 16'h0000, 1, 1), "resume1");
        apply(mk(1, 0, 16'h0000, 0, 4'h4, 4'hB, 16'h0000, 1, 0), "resume2");

        // reset wins over a simultaneous load while a value is pending
        rst = 1; en = 1; load = 1; value_in = 16'h9999;
        @(negedge clk);
        rst = 0; load = 0;
        apply(mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h0000, 0, 0), "rst_pend");
        run(15, 1, 0);
        apply(mk(1, 0, 16'h0000, 0, 4'h1, 4'hE, 16'h0000, 0, 0), "rst_discard");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
